control_unit: RTL and testbench



---
 rtl/cu_pkg.sv | 26 ++
 rtl/cu_decode.sv | 33 +++
 rtl/control_unit.sv | 161 ++++++++++++++++
 tb/tb_control_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the accumulator-machine control unit.
// Holds the FSM state enum and the 3-bit opcode encodings.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH1 = 4'd0,
    DECODE = 4'd1,
    SHIFT  = 4'd2,
    FETCH2 = 4'd3,
    MEMRD  = 4'd4,
    ALU    = 4'd5,
    WB     = 4'd6,
    MEMWR  = 4'd7,
    JUMP   = 4'd8
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode -> instruction-class decoder.
// The classes steer the FSM after DECODE / FETCH2 / MEMRD.
module cu_decode
  import cu_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       isShift,
  output logic       isMemRead,
  output logic       isStore,
  output logic       isJump,
  output logic       isAlu
);

  // Classify the opcode; exactly one of shift/memread/store/jump is set.
  always_comb begin
    isShift   = 1'b0;
    isMemRead = 1'b0;
    isStore   = 1'b0;
    isJump    = 1'b0;
    isAlu     = 1'b0;
    case (opcode)
      OP_LDA:         isMemRead = 1'b1;
      OP_ADD, OP_AND: begin
        isMemRead = 1'b1;
        isAlu     = 1'b1;
      end
      OP_STA:         isStore = 1'b1;
      OP_JMP, OP_JZ:  isJump  = 1'b1;
      default:        isShift = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle controller for the 8-bit accumulator datapath.
// Fetches one/two-byte instructions and sequences all datapath enables.
// Build option CU_MEM_WAIT_EN: when defined, memory states wait on memReady;
// when undefined, memReady is ignored and every memory access takes one cycle.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zFlag,
  input  logic       memReady,
  output logic       pcEn,
  output logic       selAddress,
  output logic       selAddressAC,
  output logic       mr,
  output logic       mw,
  output logic       wordRegEn,
  output logic       DIEn,
  output logic       dataRegEn,
  output logic       resultRegEn,
  output logic       enb,
  output logic       LSEn,
  output logic       RSEn,
  output logic       selData,
  output logic       selALUsrc,
  output logic       CEn,
  output logic       ZEn,
  output logic       NEn,
  output logic       instrDone
);

  state_t state, next;
  logic   rdy;
  logic   isShift, isMemRead, isStore, isJump, isAlu;

`ifdef CU_MEM_WAIT_EN
  assign rdy = memReady;
`else
  // Memory is assumed single-cycle; the handshake input is left unused.
  logic unused_mem_ready;
  assign unused_mem_ready = memReady;
  assign rdy = 1'b1;
`endif

  cu_decode u_decode (
    .opcode    (opcode),
    .isShift   (isShift),
    .isMemRead (isMemRead),
    .isStore   (isStore),
    .isJump    (isJump),
    .isAlu     (isAlu)
  );

  // State register; reset returns to FETCH1 and abandons any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH1;
    else     state <= next;
  end

  // Next state and outputs; outputs are forced low while reset is held so
  // no PC/AC load can slip through after reset assertion.
  always_comb begin
    next         = state;
    pcEn         = 1'b0;
    selAddress   = 1'b0;
    selAddressAC = 1'b0;
    mr           = 1'b0;
    mw           = 1'b0;
    wordRegEn    = 1'b0;
    DIEn         = 1'b0;
    dataRegEn    = 1'b0;
    resultRegEn  = 1'b0;
    enb          = 1'b0;
    LSEn         = 1'b0;
    RSEn         = 1'b0;
    selData      = 1'b0;
    selALUsrc    = 1'b0;
    CEn          = 1'b0;
    ZEn          = 1'b0;
    NEn          = 1'b0;
    instrDone    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH1: begin
          mr = 1'b1;
          if (rdy) begin
            wordRegEn = 1'b1;
            pcEn      = 1'b1;
            next      = DECODE;
          end
        end
        DECODE: begin
          DIEn = 1'b1;
          next = isShift ? SHIFT : FETCH2;
        end
        SHIFT: begin
          LSEn      = ~opcode[0];
          RSEn      = opcode[0];
          CEn       = 1'b1;
          ZEn       = 1'b1;
          NEn       = 1'b1;
          instrDone = 1'b1;
          next      = FETCH1;
        end
        FETCH2: begin
          mr = 1'b1;
          if (rdy) begin
            wordRegEn = 1'b1;
            pcEn      = 1'b1;
            if (isMemRead)    next = MEMRD;
            else if (isStore) next = MEMWR;
            else if (isJump)  next = JUMP;
            else              next = FETCH1;
          end
        end
        MEMRD: begin
          mr         = 1'b1;
          selAddress = 1'b1;
          if (rdy) begin
            dataRegEn = 1'b1;
            next      = isAlu ? ALU : WB;
          end
        end
        ALU: begin
          resultRegEn = 1'b1;
          selALUsrc   = opcode[0];
          next        = WB;
        end
        WB: begin
          enb       = 1'b1;
          ZEn       = 1'b1;
          NEn       = 1'b1;
          selData   = (opcode == OP_LDA);
          CEn       = (opcode == OP_ADD);
          instrDone = 1'b1;
          next      = FETCH1;
        end
        MEMWR: begin
          mw         = 1'b1;
          selAddress = 1'b1;
          if (rdy) begin
            instrDone = 1'b1;
            next      = FETCH1;
          end
        end
        JUMP: begin
          instrDone = 1'b1;
          // JMP (opcode[0]=0) always loads; JZ only when Z is set.
          if (!opcode[0] || zFlag) begin
            pcEn         = 1'b1;
            selAddressAC = 1'b1;
          end
          next = FETCH1;
        end
        default: next = FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction cycle templates built from the ISA rules,
// with random waits, zFlag and junk opcodes, compared cycle by cycle.
module tb_control_unit;

`ifdef CU_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [17:0] PCEN   = 18'd1 << 17;
  localparam logic [17:0] SELA   = 18'd1 << 16;
  localparam logic [17:0] SELAC  = 18'd1 << 15;
  localparam logic [17:0] MR     = 18'd1 << 14;
  localparam logic [17:0] MW     = 18'd1 << 13;
  localparam logic [17:0] WREN   = 18'd1 << 12;
  localparam logic [17:0] DIEN   = 18'd1 << 11;
  localparam logic [17:0] DREN   = 18'd1 << 10;
  localparam logic [17:0] RREN   = 18'd1 << 9;
  localparam logic [17:0] ENB    = 18'd1 << 8;
  localparam logic [17:0] LSEN   = 18'd1 << 7;
  localparam logic [17:0] RSEN   = 18'd1 << 6;
  localparam logic [17:0] SELD   = 18'd1 << 5;
  localparam logic [17:0] SELALU = 18'd1 << 4;
  localparam logic [17:0] CEN    = 18'd1 << 3;
  localparam logic [17:0] ZEN    = 18'd1 << 2;
  localparam logic [17:0] NEN    = 18'd1 << 1;
  localparam logic [17:0] DONE   = 18'd1 << 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zFlag, memReady;
  logic pcEn, selAddress, selAddressAC, mr, mw, wordRegEn, DIEn, dataRegEn;
  logic resultRegEn, enb, LSEn, RSEn, selData, selALUsrc, CEn, ZEn, NEn, instrDone;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zFlag(zFlag), .memReady(memReady),
    .pcEn(pcEn), .selAddress(selAddress), .selAddressAC(selAddressAC),
    .mr(mr), .mw(mw), .wordRegEn(wordRegEn), .DIEn(DIEn), .dataRegEn(dataRegEn),
    .resultRegEn(resultRegEn), .enb(enb), .LSEn(LSEn), .RSEn(RSEn),
    .selData(selData), .selALUsrc(selALUsrc), .CEn(CEn), .ZEn(ZEn), .NEn(NEn),
    .instrDone(instrDone)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {pcEn, selAddress, selAddressAC, mr, mw, wordRegEn, DIEn,
                     dataRegEn, resultRegEn, enb, LSEn, RSEn, selData, selALUsrc,
                     CEn, ZEn, NEn, instrDone};

  typedef struct packed {
    logic        mrdy;
    logic        zf;
    logic [2:0]  opc;
    logic [17:0] exp;
  } step_t;

  step_t q[$];
  int    done_cyc[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    mrdy_zero = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // memReady value for cycles where the controller must ignore it
  function automatic logic idle_rdy();
    return mrdy_zero ? 1'b0 : rbit();
  endfunction

  task automatic push(input logic mrdy, input logic zf, input logic [2:0] opc,
                      input logic [17:0] e);
    step_t s;
    s.mrdy = mrdy; s.zf = zf; s.opc = opc; s.exp = e;
    q.push_back(s);
  endtask

  // A memory access: optional stall cycles, then the accepting cycle.
  task automatic mem_phase(input logic [2:0] opc, input logic [17:0] hold,
                           input logic [17:0] accept, input int waits);
    int n;
    n = WAIT_EN ? waits : 0;
    for (int i = 0; i < n; i++) push(1'b0, rbit(), opc, hold);
    push(WAIT_EN ? 1'b1 : idle_rdy(), rbit(), opc, hold | accept);
  endtask

  // Expected cycles of one instruction. jz: -1 random zFlag, else forced.
  task automatic gen_instr(input logic [2:0] op, input int f1_waits,
                           input int max_w, input int jz);
    logic z;
    mem_phase(3'($urandom), MR, WREN | PCEN, f1_waits);
    push(idle_rdy(), rbit(), op, DIEN);
    if (op[2:1] == 2'b11) begin
      push(idle_rdy(), rbit(), op, (op[0] ? RSEN : LSEN) | CEN | ZEN | NEN | DONE);
      return;
    end
    mem_phase(op, MR, WREN | PCEN, $urandom_range(0, max_w));
    if (op == 3'd1) begin
      mem_phase(op, MW | SELA, DONE, $urandom_range(0, max_w));
    end else if (op[2]) begin
      z = (jz < 0) ? rbit() : logic'(jz);
      push(idle_rdy(), z, op, DONE | ((op == 3'd4 || z) ? (PCEN | SELAC) : 18'd0));
    end else begin
      mem_phase(op, MR | SELA, DREN, $urandom_range(0, max_w));
      if (op != 3'd0) push(idle_rdy(), rbit(), op, RREN | (op == 3'd3 ? SELALU : 18'd0));
      push(idle_rdy(), rbit(), op, ENB | ZEN | NEN | DONE |
           (op == 3'd0 ? SELD : 18'd0) | (op == 3'd2 ? CEN : 18'd0));
    end
  endtask

  // Play n queued cycles (n<0: all). Entered just after a rising edge.
  task automatic run(input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      memReady = s.mrdy; zFlag = s.zf; opcode = s.opc;
      @(negedge clk);
      cyc++;
      if (instrDone) done_cyc.push_back(cyc);
      check($sformatf("cycle%0d_op%0d", cyc, s.opc), 32'(obs), 32'(s.exp));
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 3'd0; zFlag = 1'b0; memReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // LDA / ADD / STA back to back with no stalls: done at 5, 11, 15
    cyc = 0; done_cyc.delete();
    gen_instr(3'd0, 0, 0, -1);
    gen_instr(3'd2, 0, 0, -1);
    gen_instr(3'd1, 0, 0, -1);
    run(-1);
    check("done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("done_lda", 32'(done_cyc[0]), 32'd5);
      check("done_add", 32'(done_cyc[1]), 32'd11);
      check("done_sta", 32'(done_cyc[2]), 32'd15);
    end

    // 3-cycle FETCH1 stall, then jumps and shifts
    gen_instr(3'd0, 3, 0, -1);
    gen_instr(3'd5, 0, 0, 1);
    gen_instr(3'd5, 0, 0, 0);
    gen_instr(3'd4, 0, 0, 0);
    gen_instr(3'd7, 1, 0, -1);
    gen_instr(3'd6, 0, 0, -1);
    gen_instr(3'd3, 0, 1, -1);
    run(-1);

    // memReady held low outside real stalls: LDA still 5 cycles without handshake
    mrdy_zero = 1'b1;
    cyc = 0; done_cyc.delete();
    gen_instr(3'd0, 0, 0, -1);
    run(-1);
    check("lda_latency", done_cyc.size() > 0 ? 32'(done_cyc[0]) : 32'd0, 32'd5);
    mrdy_zero = 1'b0;

    // random instruction stream with random stalls
    for (int i = 0; i < 80; i++)
      gen_instr(3'($urandom), $urandom_range(0, 2), 2, -1);
    run(-1);

    // reset asserted in the MEMRD cycle of an LDA with memReady high
    gen_instr(3'd0, 0, 0, -1);
    run(3);
    memReady = 1'b1; opcode = 3'd0;
    #2 rst = 1'b1;
    #1 check("rst_async_zero", 32'(obs), 32'd0);
    q.delete();
    @(negedge clk);
    check("rst_hold_zero", 32'(obs), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    memReady = 1'b0;
    #1 check("post_rst_fetch", 32'(obs & (MR | SELA)), 32'(MR));
    gen_instr(3'd2, 0, 0, -1);
    for (int i = 0; i < 20; i++)
      gen_instr(3'($urandom), $urandom_range(0, 2), 2, -1);
    run(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
